// File: rtl/dir_pad_decoder.sv
// Direction-pad front end: 2-FF synchronise, debounce and decode N raw buttons
// into a held-direction index, a press/auto-repeat strobe, a latched
// multi-press error flag and a one-hot LED mirror.
module dir_pad_decoder #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_DLY   = 50,
  parameter int REPEAT_PER   = 10,
  parameter int IDX_W        = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             dir_valid,
  output logic [IDX_W-1:0] dir_idx,
  output logic             dir_pulse,
  output logic             multi_err,
  output logic [N_BTN-1:0] led
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int ONES_W  = $clog2(N_BTN + 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_MULTI = 2'd2
  } state_t;

  logic [N_BTN-1:0]  sync1, sync2, db;
  logic [DB_W-1:0]   db_cnt [N_BTN];
  logic [ONES_W-1:0] ones;
  logic [IDX_W-1:0]  idx;
  logic              single, multi;

  state_t            state, state_n;
  logic [IDX_W-1:0]  hold_idx, hold_idx_n;
  logic [REP_W-1:0]  rep, rep_n;
  logic              pulse_n;

  // Synchroniser chain plus per-button debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Popcount and index of the (highest) set debounced bit
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (db[i]) begin
        ones = ones + 1'b1;
        idx  = IDX_W'(i);
      end
    end
    single = (ones == ONES_W'(1));
    multi  = (ones >= ONES_W'(2));
  end

  // Next-state, repeat timer and strobe decision
  always_comb begin
    state_n    = state;
    hold_idx_n = hold_idx;
    rep_n      = rep;
    pulse_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (single) begin
          state_n    = S_HOLD;
          hold_idx_n = idx;
          rep_n      = REP_W'(REPEAT_DLY - 1);
          pulse_n    = 1'b1;
        end else if (multi) begin
          state_n = S_MULTI;
        end
      end
      S_HOLD: begin
        if (ones == '0) begin
          state_n = S_IDLE;
        end else if (multi) begin
          state_n = S_MULTI;
        end else if (idx != hold_idx) begin
          hold_idx_n = idx;
          rep_n      = REP_W'(REPEAT_DLY - 1);
          pulse_n    = 1'b1;
        end else if (rep != '0) begin
          rep_n = rep - 1'b1;
        end else if (REPEAT_PER != 0) begin
          // Reload with the full period: the reload cycle itself is part of
          // the gap, giving one strobe every REPEAT_PER+1 cycles.
          rep_n   = REP_W'(REPEAT_PER);
          pulse_n = 1'b1;
        end
      end
      S_MULTI: begin
        if (ones == '0) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_idx  <= '0;
      rep       <= '0;
      dir_valid <= 1'b0;
      dir_idx   <= '0;
      dir_pulse <= 1'b0;
      multi_err <= 1'b0;
      led       <= '0;
    end else begin
      state     <= state_n;
      hold_idx  <= hold_idx_n;
      rep       <= rep_n;
      dir_pulse <= pulse_n;
      dir_valid <= (state_n == S_HOLD);
      dir_idx   <= (state_n == S_HOLD) ? hold_idx_n : '0;
      led       <= (state_n == S_HOLD) ? (N_BTN'(1) << hold_idx_n) : '0;
      multi_err <= (state_n == S_MULTI);
    end
  end

endmodule

// File: tb/tb_dir_pad_decoder.sv
// Directed bench for dir_pad_decoder: one build with auto-repeat, one with
// auto-repeat disabled.
module tb_dir_pad_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_a, btn_b;

  logic       valid_a, pulse_a, merr_a;
  logic [1:0] idx_a;
  logic [3:0] led_a;
  logic       valid_b, pulse_b, merr_b;
  logic [1:0] idx_b;
  logic [3:0] led_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dir_pad_decoder #(
    .N_BTN(4), .DEBOUNCE_CYC(4), .REPEAT_DLY(10), .REPEAT_PER(3)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_a),
    .dir_valid(valid_a), .dir_idx(idx_a), .dir_pulse(pulse_a),
    .multi_err(merr_a), .led(led_a)
  );

  dir_pad_decoder #(
    .N_BTN(4), .DEBOUNCE_CYC(4), .REPEAT_DLY(10), .REPEAT_PER(0)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_b),
    .dir_valid(valid_b), .dir_idx(idx_b), .dir_pulse(pulse_b),
    .multi_err(merr_b), .led(led_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_p;
    int   npulse;

    // Reset
    rst = 1'b1; btn_a = '0; btn_b = '0;
    step(3);
    chk("rst_valid", valid_a, 0);
    chk("rst_idx",   idx_a,   0);
    chk("rst_pulse", pulse_a, 0);
    chk("rst_merr",  merr_a,  0);
    chk("rst_led",   led_a,   0);
    chk("rst_b_led", led_b,   0);
    rst = 1'b0;
    step(2);

    // Hold btn 2 for 40 cycles: pulse at 7, 17, then every 4
    btn_a = 4'b0100;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      exp_p = (c == 7) || (c >= 17 && ((c - 17) % 4) == 0);
      chk("hold_pulse", pulse_a, exp_p);
      chk("hold_valid", valid_a, (c >= 7));
    end
    chk("hold_idx", idx_a, 2);
    chk("hold_led", led_a, 4'b0100);
    btn_a = '0;
    step(10);
    chk("rel_valid", valid_a, 0);
    chk("rel_led",   led_a,   0);

    // 2-cycle and 3-cycle glitches on btn 1 never reach the debounced state
    btn_a = 4'b0010; step(2); btn_a = '0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("gl2_pulse", pulse_a, 0);
      chk("gl2_valid", valid_a, 0);
    end
    btn_a = 4'b0010; step(3); btn_a = '0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("gl3_pulse", pulse_a, 0);
      chk("gl3_valid", valid_a, 0);
    end

    // Multi-press latching
    btn_a = 4'b0001;
    step(8);
    chk("m_hold_valid", valid_a, 1);
    chk("m_hold_idx",   idx_a,   0);
    chk("m_hold_led",   led_a,   4'b0001);
    btn_a = 4'b1001;
    step(7);
    chk("m_err",   merr_a,  1);
    chk("m_led",   led_a,   0);
    chk("m_valid", valid_a, 0);
    chk("m_pulse", pulse_a, 0);
    btn_a = 4'b0001;
    step(10);
    chk("m_stay_err",   merr_a,  1);
    chk("m_stay_valid", valid_a, 0);
    btn_a = '0;
    step(6);
    chk("m_exit_early", merr_a, 1);
    step(1);
    chk("m_exit", merr_a, 0);
    step(5);

    // Direct swap from btn 0 to btn 1 is a new press
    btn_a = 4'b0001;
    step(7);
    chk("sw_p0",   pulse_a, 1);
    chk("sw_idx0", idx_a,   0);
    step(1);
    btn_a = 4'b0010;
    step(6);
    chk("sw_gap", pulse_a, 0);
    step(1);
    chk("sw_p1",   pulse_a, 1);
    chk("sw_idx1", idx_a,   1);
    chk("sw_led1", led_a,   4'b0010);
    chk("sw_merr", merr_a,  0);
    btn_a = '0;
    step(10);

    // Reset while holding: full debounce again before the next pulse
    btn_a = 4'b0100;
    step(12);
    chk("rh_valid", valid_a, 1);
    rst = 1'b1;
    step(1);
    chk("rh_rst_valid", valid_a, 0);
    chk("rh_rst_idx",   idx_a,   0);
    chk("rh_rst_led",   led_a,   0);
    chk("rh_rst_pulse", pulse_a, 0);
    rst = 1'b0;
    step(6);
    chk("rh_early_pulse", pulse_a, 0);
    chk("rh_early_valid", valid_a, 0);
    step(1);
    chk("rh_pulse", pulse_a, 1);
    chk("rh_idx",   idx_a,   2);
    chk("rh_led",   led_a,   4'b0100);
    btn_a = '0;
    step(10);

    // Repeat disabled: one strobe for a 100-cycle hold
    btn_b = 4'b1000;
    npulse = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (pulse_b) npulse++;
    end
    chk("nr_count", npulse,  1);
    chk("nr_valid", valid_b, 1);
    chk("nr_idx",   idx_b,   3);
    chk("nr_led",   led_b,   4'b1000);
    btn_b = '0;
    step(10);
    chk("nr_rel", valid_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
